// File: rtl/pingpong_lb_pkg.sv
// Shared types and constants for the ping-pong scanline buffer.
// Default sizes match the VGA configuration; instances may override them.
package pingpong_lb_pkg;

  localparam int unsigned ADD_WIDTH = 9;
  localparam int unsigned DEPTH     = 1 << ADD_WIDTH;

  typedef logic                 bank_t;
  typedef logic [ADD_WIDTH:0]   wcnt_t;

  function automatic bank_t other_bank(input bank_t b);
    return ~b;
  endfunction

endpackage

// File: rtl/lb_bank_ram.sv
// Single-port synchronous RAM for one scanline bank.
// A read updates outdata one cycle later; otherwise outdata holds.
module lb_bank_ram #(
  parameter int unsigned Bits      = 32,
  parameter int unsigned Add_Width = 9
) (
  input  logic                 clk,
  input  logic                 cen,
  input  logic                 wen,
  input  logic [Add_Width-1:0] addr,
  input  logic [Bits-1:0]      indata,
  output logic [Bits-1:0]      outdata
);

  logic [Bits-1:0] mem [1 << Add_Width];

  always_ff @(posedge clk) begin
    if (cen) begin
      if (wen) begin
        mem[addr] <= indata;
      end else begin
        outdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/pingpong_line_buffer.sv
// Double-banked scanline buffer: the fetch side fills one bank while scanout drains the other.
// Each side swaps banks on its own line completion; full flags arbitrate ownership.
module pingpong_line_buffer
  import pingpong_lb_pkg::*;
#(
  parameter int unsigned Bits       = 32,
  parameter int unsigned Add_Width  = 9,
  parameter int unsigned Line_Words = 320
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [Bits-1:0] wr_data,
  input  logic            wr_last,
  input  logic            rd_en,
  output logic [Bits-1:0] rd_data,
  output logic            rd_valid,
  output logic            rd_eol,
  output logic            line_avail,
  output logic [1:0]      fill_level,
  output logic            underflow,
  input  logic            underflow_clr
);

  localparam logic [Add_Width-1:0] LastIdx = Add_Width'(Line_Words - 1);
  localparam logic [Add_Width-1:0] AddrOne = 1;
  localparam logic [Add_Width:0]   CntOne  = 1;

  logic [1:0]           full_q, full_d;
  bank_t                wr_bank_q, rd_bank_q, rd_sel_q;
  logic [Add_Width-1:0] wr_cnt_q, rd_cnt_q;
  logic [Add_Width:0]   len_q [2];
  logic                 rd_valid_q, rd_eol_q, underflow_q;
  logic [Bits-1:0]      rd_hold_q;
  logic [Bits-1:0]      ram_out [2];

  logic wr_accept, wr_close, rd_fire, rd_close;

  assign wr_ready   = ~full_q[wr_bank_q];
  assign line_avail = full_q[rd_bank_q];
  assign fill_level = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign underflow  = underflow_q;
  assign rd_valid   = rd_valid_q;
  assign rd_eol     = rd_eol_q;

  assign wr_accept = wr_valid & wr_ready;
  assign wr_close  = wr_accept & (wr_last | (wr_cnt_q == LastIdx));
  assign rd_fire   = rd_en & line_avail;
  assign rd_close  = rd_fire & (({1'b0, rd_cnt_q} + CntOne) == len_q[rd_bank_q]);

  // RAM output register only changes on a read, so holding uses a separate copy.
  assign rd_data = rd_valid_q ? ram_out[rd_sel_q] : rd_hold_q;

  // A close on each side always targets different banks, so both updates apply.
  always_comb begin
    full_d = full_q;
    if (wr_close) full_d[wr_bank_q] = 1'b1;
    if (rd_close) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      rd_valid_q  <= 1'b0;
      rd_eol_q    <= 1'b0;
      underflow_q <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      full_q <= full_d;
      if (wr_accept) begin
        if (wr_close) begin
          len_q[wr_bank_q] <= {1'b0, wr_cnt_q} + CntOne;
          wr_bank_q        <= other_bank(wr_bank_q);
          wr_cnt_q         <= '0;
        end else begin
          wr_cnt_q <= wr_cnt_q + AddrOne;
        end
      end
      if (rd_fire) begin
        rd_sel_q <= rd_bank_q;
        if (rd_close) begin
          rd_bank_q <= other_bank(rd_bank_q);
          rd_cnt_q  <= '0;
        end else begin
          rd_cnt_q <= rd_cnt_q + AddrOne;
        end
      end
      rd_valid_q <= rd_fire;
      rd_eol_q   <= rd_close;
      if (rd_valid_q) rd_hold_q <= rd_data;
      if (rd_en && !line_avail) begin
        underflow_q <= 1'b1;
      end else if (underflow_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic sel_wr, sel_rd;
    assign sel_wr = wr_accept & (wr_bank_q == bank_t'(b));
    assign sel_rd = rd_fire & (rd_bank_q == bank_t'(b));

    lb_bank_ram #(
      .Bits      (Bits),
      .Add_Width (Add_Width)
    ) u_ram (
      .clk     (clk),
      .cen     (sel_wr | sel_rd),
      .wen     (sel_wr),
      .addr    (sel_wr ? wr_cnt_q : rd_cnt_q),
      .indata  (wr_data),
      .outdata (ram_out[b])
    );
  end

endmodule

// File: tb/tb_pingpong_line_buffer.sv
// Scoreboard bench for pingpong_line_buffer: a queue-of-lines model predicts reads and status.
module tb_pingpong_line_buffer;

  localparam int unsigned Bits = 8;
  localparam int unsigned AW   = 2;
  localparam int unsigned LW   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [Bits-1:0] wr_data = '0;
  logic            wr_last = 1'b0;
  logic            rd_en = 1'b0;
  logic [Bits-1:0] rd_data;
  logic            rd_valid;
  logic            rd_eol;
  logic            line_avail;
  logic [1:0]      fill_level;
  logic            underflow;
  logic            underflow_clr = 1'b0;

  always #5 clk = ~clk;

  pingpong_line_buffer #(
    .Bits       (Bits),
    .Add_Width  (AW),
    .Line_Words (LW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_eol        (rd_eol),
    .line_avail    (line_avail),
    .fill_level    (fill_level),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  int tests = 0;
  int fails = 0;

  // Model: completed lines as a word queue plus a length queue; at most two complete lines.
  logic [7:0] m_cur[$];
  logic [7:0] m_data[$];
  int         m_len[$];
  int         m_rpos;
  logic       m_uf;
  logic       m_acc;
  logic       m_rdv;
  logic [7:0] m_last;
  logic [8:0] sbq[$];

  always @(posedge clk or negedge rst_n) begin
    bit ready, avail, eol;
    if (!rst_n) begin
      m_cur.delete();
      m_data.delete();
      m_len.delete();
      sbq.delete();
      m_rpos = 0;
      m_uf   = 1'b0;
      m_acc  = 1'b0;
      m_rdv  = 1'b0;
      m_last = '0;
    end else begin
      ready = (m_len.size() < 2);
      avail = (m_len.size() > 0);
      m_acc = 1'b0;
      m_rdv = 1'b0;
      if (rd_en && avail) begin
        eol    = (m_rpos == m_len[0] - 1);
        m_last = m_data.pop_front();
        sbq.push_back({eol, m_last});
        m_rdv  = 1'b1;
        if (eol) begin
          void'(m_len.pop_front());
          m_rpos = 0;
        end else begin
          m_rpos++;
        end
      end
      if (rd_en && !avail) m_uf = 1'b1;
      else if (underflow_clr) m_uf = 1'b0;
      if (wr_valid && ready) begin
        m_acc = 1'b1;
        m_cur.push_back(wr_data);
        if (wr_last || m_cur.size() == LW) begin
          foreach (m_cur[i]) m_data.push_back(m_cur[i]);
          m_len.push_back(m_cur.size());
          m_cur.delete();
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    logic [8:0] e;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_line_avail", line_avail, 0);
      chk("rst_fill_level", fill_level, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_eol", rd_eol, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_underflow", underflow, 0);
    end else begin
      chk("wr_ready", wr_ready, m_len.size() < 2);
      chk("line_avail", line_avail, m_len.size() > 0);
      chk("fill_level", fill_level, m_len.size());
      chk("underflow", underflow, m_uf);
      chk("rd_valid", rd_valid, m_rdv);
      if (rd_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty: rd_valid with data %0h but no word expected", rd_data);
        end else begin
          e = sbq.pop_front();
          chk("rd_data", rd_data, e[7:0]);
          chk("rd_eol", rd_eol, e[8]);
        end
      end else begin
        chk("rd_data_hold", rd_data, m_last);
        chk("rd_eol_idle", rd_eol, 0);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    cyc(1);

    // Two full lines, then a ninth word that must stall.
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'h10 + 8'((i / 4) * 16 + (i % 4));
      cyc(1);
    end
    wr_data = 8'h30;
    cyc(3);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (m_acc) wr_valid = 1'b0;
    end
    rd_en = 1'b0;
    wr_valid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wr_data = 8'h30 + 8'(i);
      cyc(1);
    end
    wr_valid = 1'b0;
    rd_en = 1'b1;
    cyc(4);
    rd_en = 1'b0;
    cyc(2);

    // One-word line.
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    wr_last  = 1'b1;
    cyc(1);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd_en    = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    cyc(2);

    // Underflow: sticky, cleared, and set winning over clear.
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    cyc(2);
    underflow_clr = 1'b1;
    cyc(1);
    underflow_clr = 1'b0;
    cyc(1);
    rd_en = 1'b1;
    cyc(1);
    underflow_clr = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    cyc(1);
    underflow_clr = 1'b0;
    cyc(1);

    // Reset mid-line with one full bank.
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = (i < 4) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 4);
      cyc(1);
    end
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    cyc(1);
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'h60 + 8'(i);
      cyc(1);
    end
    wr_valid = 1'b0;
    rd_en = 1'b1;
    cyc(4);
    rd_en = 1'b0;
    cyc(1);

    // Randomized traffic.
    repeat (3000) begin
      wr_valid      = ($urandom_range(0, 99) < 60);
      wr_data       = 8'($urandom);
      wr_last       = ($urandom_range(0, 4) == 0);
      rd_en         = ($urandom_range(0, 99) < 50);
      underflow_clr = ($urandom_range(0, 19) == 0);
      cyc(1);
    end
    wr_valid      = 1'b0;
    wr_last       = 1'b0;
    underflow_clr = 1'b0;
    rd_en         = 1'b1;
    cyc(20);
    rd_en = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pingpong_line_buffer.md
Name: pingpong_line_buffer

Overview:
- Double-banked (ping-pong) scanline buffer between the AXI fetch side (writer) and the VGA scanout side (reader).
- The writer fills one bank while the reader drains the other.
- Banks swap independently per side on line completion.
- Adds over the plain single-port buffer: valid/ready write handshake, per-bank full tracking, variable line length, read-valid flag, deterministic hold of read data, underflow detection.

Parameters:
- Bits, 32, word width
- Add_Width, 9, per-bank address width; bank depth = 1 << Add_Width
- Line_Words, 320, maximum words per line; must be >= 1 and <= 1 << Add_Width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write word offered
- wr_ready  out  1  buffer can accept a word
- wr_data  in  Bits  write word
- wr_last  in  1  offered word is last of line
- rd_en  in  1  scanout requests next word
- rd_data  out  Bits  read word, registered
- rd_valid  out  1  rd_data updated this cycle
- rd_eol  out  1  rd_data is last word of its line
- line_avail  out  1  a full bank is ready to read
- fill_level  out  2  number of full banks (0..2)
- underflow  out  1  sticky: rd_en seen with no line available
- underflow_clr  in  1  clears underflow

Behaviour:
- State:
  - full[1:0]
  - wr_bank, rd_bank (1 bit each)
  - wr_cnt, rd_cnt (Add_Width bits)
  - len[0..1] (Add_Width+1 bits)
- Reset (async, rst_n=0):
  - full=0, wr_bank=rd_bank=0, counts=0, len=0
  - rd_data=0, rd_valid=0, rd_eol=0, underflow=0
  - Hence wr_ready=1, line_avail=0, fill_level=0.
  - RAM contents not reset.
  - A reset mid-line discards the partial line and any full banks.
- Write side:
  - wr_ready = !full[wr_bank] (combinational).
  - Accept = wr_valid & wr_ready: RAM[wr_bank][wr_cnt] <= wr_data; wr_cnt++.
  - Line close occurs on an accepted word when wr_last=1 or wr_cnt==Line_Words-1:
    - len[wr_bank] <= wr_cnt+1, full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
  - wr_last on the first word gives a 1-word line.
  - Words are never dropped; the writer stalls while the target bank is full.
- Read side:
  - line_avail = full[rd_bank].
  - Read = rd_en & line_avail: RAM[rd_bank][rd_cnt] read.
  - Next cycle: rd_data = word, rd_valid=1, and rd_eol=1 if rd_cnt was len[rd_bank]-1.
  - Read latency is exactly 1.
  - On the last word of a line, in the same cycle as the read: full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0; otherwise rd_cnt++.
  - Cycles with no read: rd_valid=0, rd_eol=0, rd_data holds its last value (never randomised).
  - rd_en & !line_avail: no read; underflow <= 1. It holds until underflow_clr=1 or reset. Set wins over a simultaneous clear.
- Timing:
  - A written line is readable the cycle after its closing write is accepted (line_avail rises then).
  - A bank freed by the reader is writable the cycle after its last read.
- Simultaneous events:
  - Write close and read close in the same cycle always target different banks, because a bank is only written while not full and only read while full.
  - Both updates apply.
  - fill_level = full[0] + full[1], registered-state derived.

Decomposition:
- Package pingpong_lb_pkg:
  - bank index type (1 bit)
  - word-count type (Add_Width+1 bits)
  - localparam DEPTH = 1 << Add_Width
- Sub-module lb_bank_ram:
  - single-port synchronous RAM with parameters Bits and Add_Width
  - ports: addr, clk, cen, wen, indata, outdata
  - instantiated twice, one per bank
  - address/enable muxed by wr_bank/rd_bank
  - output selected by the registered rd_bank of the previous cycle

Test Plan (Bits=8, Add_Width=2, Line_Words=4 unless stated):
- Reset, then write 0x10..0x13 with wr_valid held -> after 4th accept full[0]=1, line_avail=1 next cycle, fill_level=1, wr_ready stays 1 (bank 1 empty).
- Write two 4-word lines (0x10..0x13, 0x20..0x23) with no reads -> fill_level=2, wr_ready=0; a 9th word offered stalls and is not lost.
- Then assert rd_en 8 cycles -> rd_data 0x10..0x13, 0x20..0x23, each one cycle after its rd_en; rd_eol on 0x13 and 0x23; wr_ready=1 the cycle after 0x13 is read; the stalled word is then accepted.
- Write 0xAA with wr_last=1 as the first word -> len=1; read returns 0xAA with rd_valid=1 and rd_eol=1; fill_level returns to 0.
- rd_en=1 with fill_level=0 -> rd_valid=0, rd_data unchanged, underflow=1 and sticky; underflow_clr=1 clears it next cycle; underflow_clr with simultaneous rd_en underflow keeps it 1.
- Drop rst_n mid-line after 2 of 4 words, with one full bank -> all outputs return to reset values asynchronously; a new line after release starts at bank 0, word 0.
